// File: rtl/bully_isa_pkg.sv
// Shared ISA constants for the bully core: command classes, opcodes,
// privilege modes and the execute-stage state encoding.
package bully_isa_pkg;

    localparam int unsigned CODE_TYPE_W = 3;

    localparam logic [CODE_TYPE_W-1:0] CODE_TYPE_INT = 3'b000;
    localparam logic [CODE_TYPE_W-1:0] CODE_TYPE_REG = 3'b001;
    localparam logic [CODE_TYPE_W-1:0] CODE_TYPE_IMM = 3'b010;
    localparam logic [CODE_TYPE_W-1:0] CODE_TYPE_JMP = 3'b100;
    localparam logic [CODE_TYPE_W-1:0] CODE_TYPE_CTL = 3'b111;

    // ALU opcodes (REG / IMM classes)
    localparam int unsigned CODE_OPCD_MOV = 0;
    localparam int unsigned CODE_OPCD_ADD = 1;
    localparam int unsigned CODE_OPCD_SUB = 2;
    localparam int unsigned CODE_OPCD_AND = 3;
    localparam int unsigned CODE_OPCD_OR  = 4;
    localparam int unsigned CODE_OPCD_XOR = 5;
    localparam int unsigned CODE_OPCD_CMP = 6;

    // Jump opcodes (JMP class)
    localparam int unsigned CODE_OPCD_JMP = 0;
    localparam int unsigned CODE_OPCD_JE  = 1;
    localparam int unsigned CODE_OPCD_JG  = 2;
    localparam int unsigned CODE_OPCD_SJF = 3;
    localparam int unsigned CODE_OPCD_SJB = 4;

    // Control opcodes (CTL class)
    localparam int unsigned CODE_OPCD_HLT = 0;

    localparam logic CODE_MODE_USER  = 1'b0;
    localparam logic CODE_MODE_ADMIN = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } exec_state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage: MOV/ADD/SUB/AND/OR/XOR plus
// unsigned compare results.
module exec_alu
    import bully_isa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             gt
);

    always_comb begin
        result = '0;
        case (op)
            3'(CODE_OPCD_MOV): result = b;
            3'(CODE_OPCD_ADD): result = a + b;
            3'(CODE_OPCD_SUB): result = a - b;
            3'(CODE_OPCD_AND): result = a & b;
            3'(CODE_OPCD_OR):  result = a | b;
            3'(CODE_OPCD_XOR): result = a ^ b;
            default:           result = '0;
        endcase
    end

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/exec_unit.sv
// Execute stage: captures a decoded bundle, executes it one cycle later and
// owns the register file, flags and pc. Faults are sticky until reset.
module exec_unit
    import bully_isa_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned REG_NUM   = 8
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         admin_flag,
    input  logic [2:0]                   code_type,
    input  logic [BUS_WIDTH-5:0]         opcode,
    input  logic [BUS_WIDTH-1:0]         opdata0,
    input  logic [BUS_WIDTH-1:0]         opdata1,
    input  logic                         cmd_ready,
    input  logic                         decoder_error,
    input  logic [$clog2(REG_NUM)-1:0]   dbg_sel,
    output logic [BUS_WIDTH-1:0]         dbg_data,
    output logic [BUS_WIDTH-1:0]         pc,
    output logic                         flag_eq,
    output logic                         flag_gt,
    output logic                         busy,
    output logic                         retire,
    output logic                         int_req,
    output logic [BUS_WIDTH-5:0]         int_vector,
    output logic                         halted,
    output logic                         exec_error
);

    localparam int unsigned OPW  = BUS_WIDTH - 4;
    localparam int unsigned IDXW = $clog2(REG_NUM);

    exec_state_t state, state_next;

    logic [BUS_WIDTH-1:0] regs [REG_NUM];

    logic                 cap_admin;
    logic [2:0]           cap_type;
    logic [OPW-1:0]       cap_opcode;
    logic [BUS_WIDTH-1:0] cap_op0;
    logic [BUS_WIDTH-1:0] cap_op1;

    logic [IDXW-1:0]      idx_dst;
    logic [IDXW-1:0]      idx_src;
    logic                 dst_bad;
    logic                 src_bad;
    logic [BUS_WIDTH-1:0] src_val;
    logic [BUS_WIDTH-1:0] alu_result;
    logic                 alu_eq;
    logic                 alu_gt;

    logic                 is_alu;
    logic                 is_cmp;
    logic                 is_int;
    logic                 is_hlt;
    logic                 insn_fault;
    logic [BUS_WIDTH-1:0] pc_next;
    logic                 capture;
    logic                 commit;

    assign dbg_data = regs[dbg_sel];

    // Operand fetch from the captured bundle
    assign idx_dst = cap_op0[IDXW-1:0];
    assign idx_src = cap_op1[IDXW-1:0];
    assign dst_bad = (cap_op0 >= BUS_WIDTH'(REG_NUM));
    assign src_bad = (cap_op1 >= BUS_WIDTH'(REG_NUM));
    assign src_val = (cap_type == CODE_TYPE_REG) ? regs[idx_src] : cap_op1;

    exec_alu #(
        .WIDTH (BUS_WIDTH)
    ) u_alu (
        .op     (cap_opcode[2:0]),
        .a      (regs[idx_dst]),
        .b      (src_val),
        .result (alu_result),
        .eq     (alu_eq),
        .gt     (alu_gt)
    );

    // Instruction classification, legality and next pc
    always_comb begin
        is_alu     = 1'b0;
        is_cmp     = 1'b0;
        is_int     = 1'b0;
        is_hlt     = 1'b0;
        insn_fault = 1'b0;
        pc_next    = pc + BUS_WIDTH'(1);
        case (cap_type)
            CODE_TYPE_REG, CODE_TYPE_IMM: begin
                is_cmp     = (cap_opcode == OPW'(CODE_OPCD_CMP));
                is_alu     = (cap_opcode <  OPW'(CODE_OPCD_CMP));
                insn_fault = dst_bad
                           | ((cap_type == CODE_TYPE_REG) & src_bad)
                           | (cap_opcode > OPW'(CODE_OPCD_CMP));
            end
            CODE_TYPE_JMP: begin
                insn_fault = (cap_opcode > OPW'(CODE_OPCD_SJB));
                case (cap_opcode)
                    OPW'(CODE_OPCD_JMP): pc_next = cap_op0;
                    OPW'(CODE_OPCD_JE):  pc_next = flag_eq ? cap_op0 : pc + BUS_WIDTH'(1);
                    OPW'(CODE_OPCD_JG):  pc_next = flag_gt ? cap_op0 : pc + BUS_WIDTH'(1);
                    OPW'(CODE_OPCD_SJF): pc_next = pc + cap_op0;
                    OPW'(CODE_OPCD_SJB): pc_next = pc - cap_op0;
                    default:             pc_next = pc;
                endcase
            end
            CODE_TYPE_CTL: begin
                is_hlt     = 1'b1;
                insn_fault = (cap_admin != CODE_MODE_ADMIN)
                           | (cap_opcode != OPW'(CODE_OPCD_HLT));
                pc_next    = pc;
            end
            CODE_TYPE_INT: begin
                is_int     = 1'b1;
                insn_fault = (cap_admin != CODE_MODE_ADMIN);
            end
            default: insn_fault = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_RUN: begin
                if (decoder_error) begin
                    state_next = ST_FAULT;
                end else if (cmd_ready) begin
                    capture    = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (decoder_error || cmd_ready || insn_fault) begin
                    state_next = ST_FAULT;
                end else begin
                    commit     = 1'b1;
                    state_next = is_hlt ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                if (decoder_error) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Architectural state and registered status outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= '0;
            end
            pc         <= '0;
            flag_eq    <= 1'b0;
            flag_gt    <= 1'b0;
            int_vector <= '0;
            retire     <= 1'b0;
            int_req    <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            exec_error <= 1'b0;
            cap_admin  <= 1'b0;
            cap_type   <= '0;
            cap_opcode <= '0;
            cap_op0    <= '0;
            cap_op1    <= '0;
        end else begin
            retire     <= commit;
            int_req    <= commit & is_int;
            busy       <= (state_next == ST_EXEC);
            halted     <= (state_next == ST_HALT);
            exec_error <= (state_next == ST_FAULT);
            if (capture) begin
                cap_admin  <= admin_flag;
                cap_type   <= code_type;
                cap_opcode <= opcode;
                cap_op0    <= opdata0;
                cap_op1    <= opdata1;
            end
            if (commit) begin
                pc <= pc_next;
                if (is_alu) begin
                    regs[idx_dst] <= alu_result;
                end
                if (is_cmp) begin
                    flag_eq <= alu_eq;
                    flag_gt <= alu_gt;
                end
                if (is_int) begin
                    int_vector <= cap_opcode;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed results for ALU, jumps,
// interrupts, halt and the fault paths.
module tb_exec_unit;
    import bully_isa_pkg::*;

    logic        clk;
    logic        nreset;
    logic        admin_flag;
    logic [2:0]  code_type;
    logic [27:0] opcode;
    logic [31:0] opdata0;
    logic [31:0] opdata1;
    logic        cmd_ready;
    logic        decoder_error;
    logic [2:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [31:0] pc;
    logic        flag_eq;
    logic        flag_gt;
    logic        busy;
    logic        retire;
    logic        int_req;
    logic [27:0] int_vector;
    logic        halted;
    logic        exec_error;

    int errors = 0;
    int checks = 0;

    exec_unit #(.BUS_WIDTH(32), .REG_NUM(8)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .admin_flag    (admin_flag),
        .code_type     (code_type),
        .opcode        (opcode),
        .opdata0       (opdata0),
        .opdata1       (opdata1),
        .cmd_ready     (cmd_ready),
        .decoder_error (decoder_error),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data),
        .pc            (pc),
        .flag_eq       (flag_eq),
        .flag_gt       (flag_gt),
        .busy          (busy),
        .retire        (retire),
        .int_req       (int_req),
        .int_vector    (int_vector),
        .halted        (halted),
        .exec_error    (exec_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [31:0] expected);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, expected);
    endtask

    task automatic do_reset();
        nreset        = 1'b0;
        cmd_ready     = 1'b0;
        decoder_error = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic drive(input logic adm, input logic [2:0] ct, input logic [27:0] opc,
                         input logic [31:0] d0, input logic [31:0] d1);
        admin_flag = adm;
        code_type  = ct;
        opcode     = opc;
        opdata0    = d0;
        opdata1    = d1;
    endtask

    // Issue one command and run through its EXEC cycle; retire is then visible.
    task automatic run_cmd(input logic adm, input logic [2:0] ct, input logic [27:0] opc,
                           input logic [31:0] d0, input logic [31:0] d1);
        drive(adm, ct, opc, d0, d1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
    endtask

    initial begin
        nreset = 1'b0; admin_flag = 1'b0; code_type = 3'b000; opcode = '0;
        opdata0 = '0; opdata1 = '0; cmd_ready = 1'b0; decoder_error = 1'b0; dbg_sel = '0;

        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_retire", 32'(retire), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_err", 32'(exec_error), 32'h0);
        check("rst_flags", {30'h0, flag_eq, flag_gt}, 32'h0);
        check("rst_intvec", 32'(int_vector), 32'h0);
        check_reg("rst_r1", 3'd1, 32'h0);

        // IMM MOV r1 = 5, stepwise latency
        drive(1'b0, CODE_TYPE_IMM, 28'd0, 32'd1, 32'd5);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("mov_busy_exec", 32'(busy), 32'h1);
        check("mov_retire_early", 32'(retire), 32'h0);
        check("mov_pc_early", pc, 32'h0);
        tick();
        check("mov_retire", 32'(retire), 32'h1);
        check("mov_busy_done", 32'(busy), 32'h0);
        check("mov_pc", pc, 32'h1);
        check_reg("mov_r1", 3'd1, 32'h5);
        tick();
        check("mov_retire_pulse", 32'(retire), 32'h0);

        run_cmd(1'b0, CODE_TYPE_IMM, 28'd0, 32'd2, 32'hFFFF_FFFE);
        check_reg("mov_r2", 3'd2, 32'hFFFF_FFFE);
        run_cmd(1'b0, CODE_TYPE_REG, 28'd1, 32'd2, 32'd1);
        check_reg("add_wrap_r2", 3'd2, 32'h0000_0003);
        check("add_flags", {30'h0, flag_eq, flag_gt}, 32'h0);
        check("add_pc", pc, 32'h3);

        run_cmd(1'b0, CODE_TYPE_IMM, 28'd6, 32'd1, 32'd4);
        check("cmp_gt_flags", {30'h0, flag_eq, flag_gt}, 32'h1);
        check_reg("cmp_no_write", 3'd1, 32'h5);
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd2, 32'h20, 32'h0);
        check("jg_taken", pc, 32'h20);
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd4, 32'h30, 32'h0);
        check("sjb_wrap", pc, 32'hFFFF_FFF0);
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd1, 32'h40, 32'h0);
        check("je_not_taken", pc, 32'hFFFF_FFF1);
        run_cmd(1'b0, CODE_TYPE_IMM, 28'd6, 32'd1, 32'd5);
        check("cmp_eq_flags", {30'h0, flag_eq, flag_gt}, 32'h2);
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd1, 32'h40, 32'h0);
        check("je_taken", pc, 32'h40);
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd3, 32'h10, 32'h0);
        check("sjf", pc, 32'h50);
        run_cmd(1'b0, CODE_TYPE_IMM, 28'd2, 32'd2, 32'd5);
        check_reg("sub_wrap_r2", 3'd2, 32'hFFFF_FFFE);
        run_cmd(1'b0, CODE_TYPE_REG, 28'd5, 32'd2, 32'd1);
        check_reg("xor_r2", 3'd2, 32'hFFFF_FFFB);
        check("xor_pc", pc, 32'h52);

        // Admin INT then HLT
        run_cmd(1'b1, CODE_TYPE_INT, 28'd1, 32'h0, 32'h0);
        check("int_req", 32'(int_req), 32'h1);
        check("int_vector", 32'(int_vector), 32'h1);
        check("int_pc", pc, 32'h53);
        tick();
        check("int_req_pulse", 32'(int_req), 32'h0);
        run_cmd(1'b1, CODE_TYPE_CTL, 28'd0, 32'h0, 32'h0);
        check("hlt_halted", 32'(halted), 32'h1);
        check("hlt_retire", 32'(retire), 32'h1);
        check("hlt_pc", pc, 32'h53);
        run_cmd(1'b0, CODE_TYPE_IMM, 28'd0, 32'd3, 32'd9);
        check("halt_ignore_retire", 32'(retire), 32'h0);
        check("halt_ignore_pc", pc, 32'h53);
        check_reg("halt_ignore_r3", 3'd3, 32'h0);
        check("halt_still", 32'(halted), 32'h1);

        // User INT faults with no side effects; later commands ignored
        do_reset();
        run_cmd(1'b0, CODE_TYPE_INT, 28'd1, 32'h0, 32'h0);
        check("uint_err", 32'(exec_error), 32'h1);
        check("uint_no_req", 32'(int_req), 32'h0);
        check("uint_no_retire", 32'(retire), 32'h0);
        check("uint_vec", 32'(int_vector), 32'h0);
        run_cmd(1'b1, CODE_TYPE_IMM, 28'd0, 32'd1, 32'd7);
        check_reg("fault_ignore_r1", 3'd1, 32'h0);
        check("fault_ignore_pc", pc, 32'h0);
        check("fault_busy", 32'(busy), 32'h0);

        // Overrun: cmd_ready held across two cycles
        do_reset();
        drive(1'b0, CODE_TYPE_IMM, 28'd0, 32'd3, 32'd7);
        cmd_ready = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b0;
        check("ovr_err", 32'(exec_error), 32'h1);
        check("ovr_retire", 32'(retire), 32'h0);
        check_reg("ovr_r3", 3'd3, 32'h0);
        tick();
        check("ovr_retire_late", 32'(retire), 32'h0);
        check("ovr_pc", pc, 32'h0);

        // decoder_error during EXEC suppresses writeback
        do_reset();
        drive(1'b0, CODE_TYPE_IMM, 28'd0, 32'd4, 32'd9);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        decoder_error = 1'b1;
        tick();
        decoder_error = 1'b0;
        check("decerr_err", 32'(exec_error), 32'h1);
        check("decerr_retire", 32'(retire), 32'h0);
        check_reg("decerr_r4", 3'd4, 32'h0);

        // Illegal encodings
        do_reset();
        run_cmd(1'b1, 3'b101, 28'd0, 32'h0, 32'h0);
        check("bad_type_err", 32'(exec_error), 32'h1);
        do_reset();
        check("reset_clears_err", 32'(exec_error), 32'h0);
        run_cmd(1'b0, CODE_TYPE_IMM, 28'd0, 32'd8, 32'd1);
        check("bad_dst_err", 32'(exec_error), 32'h1);
        do_reset();
        run_cmd(1'b0, CODE_TYPE_REG, 28'd7, 32'd1, 32'd1);
        check("bad_opcode_err", 32'(exec_error), 32'h1);
        do_reset();
        run_cmd(1'b0, CODE_TYPE_JMP, 28'd5, 32'h10, 32'h0);
        check("bad_jmp_err", 32'(exec_error), 32'h1);
        check("bad_jmp_pc", pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of `decoder`; consumes its decoded command bundle on each `cmd_ready` pulse.
- Holds the architectural register file, compare flags and instruction pointer.
- Performs MOV/ALU/CMP, jumps, halt and software interrupt.
- Any decode, overrun or privilege fault drops it into a sticky fault state.

Parameters:
- BUS_WIDTH, 32, data and register width; opcode width is BUS_WIDTH-4.
- REG_NUM, 8, number of general registers; index width is clog2(REG_NUM).

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  synchronous active-low reset.
- admin_flag  in  1  command privilege bit from decoder.
- code_type  in  3  command class from decoder.
- opcode  in  BUS_WIDTH-4  operation code from decoder.
- opdata0  in  BUS_WIDTH  first operand word: destination register index, or jump target/offset.
- opdata1  in  BUS_WIDTH  second operand word: source register index or immediate.
- cmd_ready  in  1  one-cycle strobe; the bundle is valid this cycle.
- decoder_error  in  1  decoder fault indication.
- dbg_sel  in  clog2(REG_NUM)  register-file debug read select.
- dbg_data  out  BUS_WIDTH  combinational read of reg[dbg_sel].
- pc  out  BUS_WIDTH  instruction pointer; counts retired instructions.
- flag_eq  out  1  last CMP result: equal.
- flag_gt  out  1  last CMP result: greater (unsigned).
- busy  out  1  high in the EXEC state.
- retire  out  1  one-cycle pulse per completed instruction.
- int_req  out  1  one-cycle software interrupt pulse.
- int_vector  out  BUS_WIDTH-4  vector captured from opcode on INT.
- halted  out  1  core is halted.
- exec_error  out  1  sticky fault, cleared only by reset.

Behaviour:
- Reset (nreset low at a clk edge):
  - All registers, pc, flags, int_vector → 0.
  - busy, retire, int_req, halted, exec_error → 0.
  - State → RUN.
  - Reset during EXEC aborts the instruction with no writeback.
- States and transitions:
  - RUN: cmd_ready=1 → capture the bundle → EXEC.
  - EXEC: always one cycle; commit → RUN, or → HALT (on HLT), or → FAULT (on any fault).
  - HALT: ignores cmd_ready.
  - FAULT: ignores cmd_ready.
- decoder_error=1 in any state except FAULT → FAULT on the next edge, including during EXEC (the commit is suppressed).
- Latency: cmd_ready in cycle N → writeback, pc update and retire pulse at the edge ending cycle N+1.
- Overrun: cmd_ready=1 while in EXEC → FAULT; the in-flight instruction is not committed.
- Type REG (001) and IMM (010):
  - dst = opdata0; src = reg[opdata1] for REG, opdata1 for IMM.
  - opcode: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 CMP.
  - ADD and SUB wrap modulo 2^BUS_WIDTH; no carry is kept.
  - CMP writes no register: flag_eq = (reg[dst]==src), flag_gt = (reg[dst]>src), unsigned.
  - Flags change only on CMP.
  - dst ≥ REG_NUM, (REG and opdata1 ≥ REG_NUM), or opcode > 6 → FAULT.
- Type JMP (100):
  - 0 JMP: pc = opdata0.
  - 1 JE: pc = opdata0 if flag_eq, else pc+1.
  - 2 JG: pc = opdata0 if flag_gt, else pc+1.
  - 3 SJF: pc = pc+opdata0.
  - 4 SJB: pc = pc-opdata0.
  - All pc arithmetic wraps modulo 2^BUS_WIDTH.
  - opcode > 4 → FAULT.
- Non-jump instructions set pc = pc+1 on retire.
- Type CTL (111): opcode 0 HLT → halted=1, pc unchanged, retire pulses; other opcodes → FAULT.
- Type INT (000): int_req pulses in the retire cycle; int_vector = opcode; pc+1.
- Privilege: CTL or INT with admin_flag=0 → FAULT with no side effects.
- Undefined code_type (011, 101, 110) → FAULT.
- FAULT: exec_error=1, busy=0, no retire; state holds until reset.

Decomposition:
- Shared package `bully_isa_pkg`:
  - CODE_TYPE_* constants.
  - CODE_OPCD_* constants.
  - CODE_MODE_* constants.
  - Exec state encoding.
  - Reused by `decoder`, its bench and this block.
- One sub-module, `exec_alu`: combinational MOV/ADD/SUB/AND/OR/XOR/CMP, producing result, eq and gt.
- Register file, pc and the FSM stay in `exec_unit`.

Test Plan:
- Reset, then IMM MOV opdata0=1, opdata1=5 → reg1=5, pc=1, retire 2 cycles after cmd_ready, busy high 1 cycle.
- reg1=5; REG ADD dst=2, src=1 (reg2=0xFFFFFFFE beforehand) → reg2=0x00000003 (wrap); flags unchanged.
- IMM CMP dst=1, imm=4 → flag_gt=1, flag_eq=0; JG opdata0=0x20 → pc=0x20. Then SJB 0x30 → pc=0xFFFFFFF0.
- User INT opcode=1 → exec_error=1, no int_req; further commands ignored. Same with admin_flag=1 from reset → int_req pulse, int_vector=1.
- Admin HLT → halted=1, pc held. cmd_ready asserted on back-to-back cycles → FAULT, no second retire.
- decoder_error asserted during EXEC of IMM MOV → no writeback, exec_error=1. code_type=101 → exec_error=1.
